// File: rtl/inpmem_reader_if.sv
// inpmem_reader_if: control, memory-port and output-stream signals of the input-memory reader.
interface inpmem_reader_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] stride;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic              mem_CEN;
  logic              mem_WEN;
  logic [ADDR_W-1:0] mem_A;
  logic [DATA_W-1:0] mem_Q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  modport master (
    input  start, base_addr, stride, length, mem_Q, out_ready,
    output busy, done, mem_CEN, mem_WEN, mem_A, out_data, out_valid
  );
  modport slave (
    output start, base_addr, stride, length, mem_Q, out_ready,
    input  busy, done, mem_CEN, mem_WEN, mem_A, out_data, out_valid
  );
endinterface

// File: rtl/inpmem_reader.sv
// inpmem_reader: strided streaming reader from the banked input memory into a credit-limited output FIFO.
module inpmem_reader #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  inpmem_reader_if.master   bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, stride_q, stride_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              inflight_q;
  logic [CW-1:0]     count_q, count_d;
  logic [CW:0]       occ;
  logic [PW-1:0]     wr_q, rd_q;
  logic [DATA_W-1:0] fifo_q [DEPTH];
  logic              issue, push, pop;
  // Credit check uses registered occupancy only, so out_ready never reaches the memory port.
  always_comb begin
    occ     = {1'b0, count_q} + (CW+1)'(inflight_q);
    issue   = state_q == ISSUE && occ < (CW+1)'(DEPTH);
    push    = inflight_q;
    pop     = count_q != '0 && bus.out_ready;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (bus.start) begin
        addr_d   = bus.base_addr;
        stride_d = bus.stride;
        cnt_d    = bus.length;
        state_d  = bus.length != '0 ? ISSUE : DONE;
      end
      ISSUE: if (issue) begin
        addr_d  = addr_q + stride_q;
        cnt_d   = cnt_q - LEN_W'(1);
        state_d = cnt_q == LEN_W'(1) ? DRAIN : ISSUE;
      end
      DRAIN: state_d = !inflight_q && count_d == '0 ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      cnt_q      <= cnt_d;
      inflight_q <= issue;
      count_q    <= count_d;
      if (push) begin
        fifo_q[wr_q] <= bus.mem_Q;
        wr_q         <= wr_q == PW'(DEPTH - 1) ? '0 : wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q == PW'(DEPTH - 1) ? '0 : rd_q + PW'(1);
    end
  end
  assign bus.mem_CEN   = !issue;
  assign bus.mem_WEN   = 1'b1;
  assign bus.mem_A     = addr_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = state_q == DONE;
  assign bus.out_valid = count_q != '0;
  assign bus.out_data  = fifo_q[rd_q];
endmodule

// File: tb/tb_inpmem_reader.sv
// tb_inpmem_reader: scoreboard bench; stimulus queues expected addresses/bytes, a negedge monitor checks them.
module tb_inpmem_reader;
  localparam int AW = 15, DW = 8, LW = 16, DEPTH = 4;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  inpmem_reader_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus();
  inpmem_reader #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] exp_a [$];
  logic [DW-1:0] exp_d [$];
  int total = 0, bad = 0, cyc = 0, t0 = 0, n0 = 0, iss0 = 0;
  int done_cnt = 0, issued = 0, occ = 0, done_cyc = 0, fv_cyc = -1;
  logic [3:0] rdy_pat = 4'b1111;
  logic [1:0] ph = 0;
  logic prev_stall = 0;
  logic [DW-1:0] prev_data = 0;
  always @(posedge clk) if (!bus.mem_CEN) bus.mem_Q <= mem[bus.mem_A];
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    bus.out_ready = rdy_pat[ph];
    ph = ph + 2'd1;
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 1);
        chk("hold_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (!bus.mem_CEN) begin
        issued++;
        occ++;
        chk("issue_expected", 32'(exp_a.size() > 0), 1);
        if (exp_a.size() > 0) chk("mem_A", 32'(bus.mem_A), 32'(exp_a.pop_front()));
      end
      if (bus.out_valid && fv_cyc < t0) fv_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        occ--;
        chk("byte_expected", 32'(exp_d.size() > 0), 1);
        if (exp_d.size() > 0) chk("out_data", 32'(bus.out_data), 32'(exp_d.pop_front()));
      end
      if (!bus.mem_CEN) chk("occupancy", 32'(occ <= DEPTH), 1);
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", 32'(bus.busy), 1);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end else begin
      prev_stall = 0;
      occ = 0;
    end
  end
  task automatic go(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [LW-1:0] l);
    logic [AW-1:0] a = b;
    for (int i = 0; i < int'(l); i++) begin
      exp_a.push_back(a);
      exp_d.push_back(mem[a]);
      a = a + s;
    end
    n0   = done_cnt;
    iss0 = issued;
    bus.start = 1; bus.base_addr = b; bus.stride = s; bus.length = l;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 0;
  endtask
  task automatic check_xfer(input int l, input int ed, input int ef);
    int k = 0;
    while (done_cnt == n0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("done_seen", done_cnt, n0 + 1);
    if (ed >= 0) chk("done_cycle", done_cyc - t0, ed);
    if (ef >= 0) chk("first_valid", fv_cyc - t0, ef);
    chk("cen_count", issued - iss0, l);
    chk("bytes_left", exp_d.size(), 0);
    chk("busy_after", 32'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("single_done", done_cnt, n0 + 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.start = 0; bus.base_addr = 0; bus.stride = 0; bus.length = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i ^ (i >> 8) ^ 8'h5A);
    for (int i = 0; i < 8; i++) mem[15'h0100 + i] = 8'hA0 + 8'(i);
    mem[15'h7FFE] = 8'h11; mem[15'h0001] = 8'h22; mem[15'h0004] = 8'h33; mem[15'h0007] = 8'h44;
    #12;
    chk("rst_mem_CEN", 32'(bus.mem_CEN), 1);
    chk("rst_mem_WEN", 32'(bus.mem_WEN), 1);
    chk("rst_mem_A", 32'(bus.mem_A), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    @(posedge clk); #1; rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    go(15'h0100, 15'd1, 16'd8);
    check_xfer(8, 11, 3);
    go(15'h7FFE, 15'd3, 16'd4);
    check_xfer(4, 7, 3);
    rdy_pat = 4'b1001;
    go(15'h0200, 15'd1, 16'd16);
    check_xfer(16, -1, 3);
    rdy_pat = 4'b1111;
    go(15'h0300, 15'd1, 16'd0);
    chk("zero_busy_c1", 32'(bus.busy), 1);
    chk("zero_done_c1", 32'(bus.done), 1);
    @(posedge clk); #1;
    chk("zero_busy_c2", 32'(bus.busy), 0);
    chk("zero_done_c2", 32'(bus.done), 0);
    check_xfer(0, 1, -1);
    go(15'h0100, 15'd1, 16'd8);
    @(posedge clk); #1;
    bus.start = 1; bus.base_addr = 15'h7FFE; bus.stride = 15'd3; bus.length = 16'd4;
    @(posedge clk); #1;
    bus.start = 0;
    check_xfer(8, 11, 3);
    go(15'h0200, 15'd2, 16'd8);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("arst_mem_CEN", 32'(bus.mem_CEN), 1);
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    exp_a.delete();
    exp_d.delete();
    @(posedge clk); #3;
    rst_n = 1;
    @(posedge clk); #1;
    go(15'h0100, 15'd1, 16'd8);
    check_xfer(8, 11, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inpmem_reader.md
# inpmem_reader

Streaming read initiator for the banked input memory. On a start pulse it walks a strided address sequence through the memory's active-low chip-enable/write-enable port, absorbs the memory's one-cycle read latency, and delivers the bytes in order on a valid/ready stream toward the systolic array row feeders. A small credit-controlled FIFO lets it sustain one byte per cycle under backpressure without any combinational path from `out_ready` to the memory port.

## Interface
- `ADDR_W`, 15: memory address width (bank select in [14:8], row in [7:0]).
- `DATA_W`, 8: memory/stream data width.
- `LEN_W`, 16: transfer length counter width.
- `DEPTH`, 4: output FIFO depth. Must be ≥ 3 for 1 byte/cycle throughput; must be ≥ 2.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request. Ignored while `busy`=1.
- `base_addr`  in  ADDR_W: first address. Sampled on accepted `start`.
- `stride`  in  ADDR_W: address increment. Sampled on accepted `start`.
- `length`  in  LEN_W: number of bytes, 0..2^LEN_W−1. Sampled on accepted `start`.
- `busy`  out  1: high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1: one-cycle pulse when the transfer completes.
- `mem_CEN`  out  1: memory chip enable, active low.
- `mem_WEN`  out  1: memory write enable, active low. Constant 1, so the block only reads.
- `mem_A`  out  ADDR_W: memory address.
- `mem_Q`  in  DATA_W: memory read data. Valid in the cycle after the cycle `mem_CEN`=0.
- `out_data`  out  DATA_W: stream data, driven from the FIFO head.
- `out_valid`  out  1: stream valid.
- `out_ready`  in  1: stream ready. A transfer occurs when `out_valid` & `out_ready`.

## Operation
- States:
  - IDLE: waits for `start`.
  - ISSUE: issues reads.
  - DRAIN: all reads issued, FIFO not yet empty.
  - DONE: one cycle; `done`=1 here.
- IDLE + `start`:
  - Latch `base_addr`, `stride`, `length`.
  - Set `issue_cnt`=`length` and `addr`=`base_addr`.
  - Next state is ISSUE if `length`≠0, else DONE.
- ISSUE, read issue rule:
  - Occupancy = `fifo_count` + `inflight` (0 or 1), computed from registered state only.
  - In a cycle with occupancy < DEPTH: drive `mem_CEN`=0 and `mem_A`=`addr`.
  - At that clock edge: `addr` += `stride`, wrapping modulo 2^ADDR_W; `issue_cnt` −= 1; `inflight`=1.
  - Otherwise `mem_CEN`=1 and `inflight`=0 at the next edge.
- Read return: when `inflight`=1, `mem_Q` is written into the FIFO at that clock edge. The issue rule guarantees the FIFO is never full when data lands.
- ISSUE → DRAIN at the edge that issues the last read (`issue_cnt` reaches 0).
- DRAIN → DONE when `inflight`=0, `fifo_count`=0, and no pop is pending. In practice: at the edge where the final byte is popped, or later.
- DONE → IDLE unconditionally. A `start` arriving in the DONE cycle is ignored.
- Address arithmetic:
  - Unsigned, wraps modulo 2^ADDR_W.
  - `stride`=0 re-reads `base_addr` `length` times.
  - Crossing a bank boundary (bit 8 carry) needs no special handling.
- FIFO:
  - Simultaneous push and pop in one cycle leaves `fifo_count` unchanged.
  - Data order equals issue order.
- `mem_CEN`, `mem_A` and `out_valid` are purely functions of registered state.

## Timing
- Reset values:
  - `mem_CEN`=1, `mem_WEN`=1, `mem_A`=0.
  - `busy`=0, `done`=0, `out_valid`=0, `out_data`=0.
  - FIFO empty, `inflight`=0, state IDLE.
- Latency, `out_ready` held 1:
  - `start` at cycle 0; first `mem_CEN`=0 at cycle 1.
  - First `out_valid` at cycle 3.
  - Last byte accepted at cycle 2+`length`.
  - `done` at cycle 3+`length`.
- Throughput: one byte/cycle sustained when DEPTH ≥ 3 and `out_ready`=1.
- Backpressure:
  - With `out_ready`=0, at most DEPTH reads are outstanding or buffered.
  - `mem_CEN` stays 1 until a pop frees a slot.
  - The freed slot is used for an issue on the cycle after the pop.
- `out_valid` and `out_data` must hold stable while `out_valid`=1 and `out_ready`=0.
- Reset mid-transfer:
  - All state clears immediately and asynchronously. `mem_CEN` goes to 1 without waiting for a clock.
  - Buffered data is discarded and no `done` is produced.

## Test plan
- Basic read: preload addresses 0x0100–0x0107 with 0xA0–0xA7; `base`=0x0100, `stride`=1, `length`=8, `out_ready`=1 → stream A0..A7 on cycles 3–10, `done` on cycle 11, exactly 8 `mem_CEN` lows.
- Strided wrap: `base`=0x7FFE, `stride`=3, `length`=4 → `mem_A` sequence 0x7FFE, 0x0001, 0x0004, 0x0007; data in that order.
- Backpressure: `length`=16, `out_ready` toggles 1,0,0,1 repeating → no lost or duplicated bytes, held data stable when stalled, `fifo_count`+`inflight` never exceeds 4.
- Zero length: `length`=0 → no `mem_CEN` low, `out_valid` stays 0, `done` pulses at cycle 1, `busy` high only in that cycle.
- Start while busy: second `start` with different `base` during a transfer → ignored; only the first transfer's data appears, single `done`.
- Async reset: assert `rst_n`=0 mid-transfer between clock edges → `mem_CEN`=1 and `out_valid`=0 immediately; after release, a new `start` completes normally with correct data.
